// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-RAM arbiter.
// Contents: owner_t (which port last used the RAM), the owner after reset,
// and the width/ceiling of the CPU stall counter.
// Build option: DMEM_ARB_RR_EN selects round-robin in the users of this
// package; the package itself is identical in both builds.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam owner_t RESET_OWNER = OWN_LDR;

    localparam int                 STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection for the data-RAM arbiter.
// Ports:
//   i_cpu_req / i_ldr_req  requests from the two ports
//   i_lock                 loader lock in force (loader owns the RAM)
//   i_last_owner           port granted most recently   (DMEM_ARB_RR_EN only)
//   i_burst_cnt            consecutive grants to owner  (DMEM_ARB_RR_EN only)
//   o_cpu_gnt / o_ldr_gnt  one-hot-or-zero grant
// Build option: DMEM_ARB_RR_EN = round-robin with burst limit; otherwise the
// CPU always wins contention.
module dmem_arb_pick
    import dmem_arb_pkg::*;
`ifdef DMEM_ARB_RR_EN
#(
    parameter int MAX_BURST = 4,
    parameter int BW        = 3
)
`endif
(
    input  logic          i_cpu_req,
    input  logic          i_ldr_req,
    input  logic          i_lock,
`ifdef DMEM_ARB_RR_EN
    input  owner_t        i_last_owner,
    input  logic [BW-1:0] i_burst_cnt,
`endif
    output logic          o_cpu_gnt,
    output logic          o_ldr_gnt
);

    logic w_cpu_pref;

`ifdef DMEM_ARB_RR_EN
    logic w_keep;
    // burst_cnt of zero means nothing has been granted since reset, so the
    // reset owner has no run to extend and the other port goes first.
    assign w_keep     = (i_burst_cnt != '0) && (i_burst_cnt < BW'(MAX_BURST));
    assign w_cpu_pref = (i_last_owner == OWN_CPU) ? w_keep : !w_keep;
`else
    assign w_cpu_pref = 1'b1;
`endif

    // While locked the CPU is shut out; the loader gets the RAM only if it
    // actually requests, otherwise the RAM idles.
    assign o_cpu_gnt = !i_lock && i_cpu_req && (!i_ldr_req || w_cpu_pref);
    assign o_ldr_gnt = i_ldr_req && !o_cpu_gnt;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data RAM between the CPU and a loader.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   i_cpu_req/we/addr/wdata            CPU access request
//   o_cpu_ack, o_cpu_rdata, o_cpu_stall CPU completion, read data, stall
//   i_ldr_req/we/addr/wdata, i_ldr_lock loader access request and lock
//   o_ldr_ack, o_ldr_rdata             loader completion and read data
//   o_mem_we/addr/wdata, i_mem_rdata   RAM port (asynchronous read)
//   o_stall_cnt                        saturating count of CPU stall cycles
// Build option: DMEM_ARB_RR_EN = round-robin arbitration limited to
// MAX_BURST consecutive grants; otherwise fixed priority to the CPU.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_cpu_req,
    input  logic               i_cpu_we,
    input  logic [AW-1:0]      i_cpu_addr,
    input  logic [DW-1:0]      i_cpu_wdata,
    output logic               o_cpu_ack,
    output logic [DW-1:0]      o_cpu_rdata,
    output logic               o_cpu_stall,
    input  logic               i_ldr_req,
    input  logic               i_ldr_we,
    input  logic [AW-1:0]      i_ldr_addr,
    input  logic [DW-1:0]      i_ldr_wdata,
    input  logic               i_ldr_lock,
    output logic               o_ldr_ack,
    output logic [DW-1:0]      o_ldr_rdata,
    output logic               o_mem_we,
    output logic [AW-1:0]      o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
    input  logic [DW-1:0]      i_mem_rdata,
    output logic [STALL_W-1:0] o_stall_cnt
);

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("dmem_arbiter: MAX_BURST must be at least 1");
    end

    logic               w_cpu_gnt;
    logic               w_ldr_gnt;
    logic               w_cpu_ack;
    logic               w_ldr_ack;
    logic               w_lock_active;
    logic               r_locked;
    logic [STALL_W-1:0] r_stall_cnt;

    // Dropping ldr_lock releases the RAM in that same cycle, so the normal
    // rules decide the winner while locked clears at the edge.
    assign w_lock_active = r_locked && i_ldr_lock;

`ifdef DMEM_ARB_RR_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    owner_t        r_last_owner;
    logic [BW-1:0] r_burst_cnt;
    owner_t        w_owner;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .BW        (BW)
    ) u_pick (
        .i_cpu_req    (i_cpu_req),
        .i_ldr_req    (i_ldr_req),
        .i_lock       (w_lock_active),
        .i_last_owner (r_last_owner),
        .i_burst_cnt  (r_burst_cnt),
        .o_cpu_gnt    (w_cpu_gnt),
        .o_ldr_gnt    (w_ldr_gnt)
    );

    assign w_owner = w_cpu_ack ? OWN_CPU : OWN_LDR;

    // burst_cnt stops at MAX_BURST: beyond that point only "reached" matters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= RESET_OWNER;
            r_burst_cnt  <= '0;
        end else if (w_cpu_ack || w_ldr_ack) begin
            r_last_owner <= w_owner;
            r_burst_cnt  <= (w_owner != r_last_owner)         ? BW'(1) :
                            (r_burst_cnt == BW'(MAX_BURST))    ? r_burst_cnt :
                                                                 r_burst_cnt + BW'(1);
        end
    end
`else
    dmem_arb_pick u_pick (
        .i_cpu_req (i_cpu_req),
        .i_ldr_req (i_ldr_req),
        .i_lock    (w_lock_active),
        .o_cpu_gnt (w_cpu_gnt),
        .o_ldr_gnt (w_ldr_gnt)
    );
`endif

    // Reset abandons the in-flight cycle: no ack, no RAM write.
    assign w_cpu_ack = w_cpu_gnt && !reset;
    assign w_ldr_ack = w_ldr_gnt && !reset;

    assign o_cpu_ack   = w_cpu_ack;
    assign o_ldr_ack   = w_ldr_ack;
    assign o_cpu_stall = i_cpu_req && !w_cpu_ack;

    assign o_mem_we    = w_cpu_ack ? i_cpu_we    : w_ldr_ack ? i_ldr_we    : 1'b0;
    assign o_mem_addr  = w_cpu_ack ? i_cpu_addr  : w_ldr_ack ? i_ldr_addr  : '0;
    assign o_mem_wdata = w_cpu_ack ? i_cpu_wdata : w_ldr_ack ? i_ldr_wdata : '0;
    assign o_cpu_rdata = w_cpu_ack ? i_mem_rdata : '0;
    assign o_ldr_rdata = w_ldr_ack ? i_mem_rdata : '0;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_locked    <= (r_locked || w_ldr_ack) && i_ldr_lock;
            r_stall_cnt <= (o_cpu_stall && r_stall_cnt != STALL_MAX) ?
                           r_stall_cnt + STALL_W'(1) : r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// behavioural single-port RAM (synchronous write, asynchronous read).
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack, cpu_stall;
    logic [7:0]  cpu_rdata;
    logic        ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
    logic [7:0]  ldr_addr = '0, ldr_wdata = '0;
    logic        ldr_ack;
    logic [7:0]  ldr_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stall_cnt;
    logic [7:0]  ram [256];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_stall (cpu_stall),
        .i_ldr_req   (ldr_req),
        .i_ldr_we    (ldr_we),
        .i_ldr_addr  (ldr_addr),
        .i_ldr_wdata (ldr_wdata),
        .i_ldr_lock  (ldr_lock),
        .o_ldr_ack   (ldr_ack),
        .o_ldr_rdata (ldr_rdata),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_stall_cnt (stall_cnt)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #1;
        vecs++; if (cpu_ack !== 1'b0) begin errs++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
        cyc();
        reset = 0;
        #1;
        vecs++; if (ldr_ack !== 1'b0) begin errs++; $display("FAIL reset_ldr_ack: got %b want 0", ldr_ack); end
        vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vecs++; if (mem_addr !== 8'h00) begin errs++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        vecs++; if (mem_wdata !== 8'h00) begin errs++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        vecs++; if (stall_cnt !== 16'h0000) begin errs++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt); end
        vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
        cyc();
    endtask

    task automatic test_ldr_write();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h10; ldr_wdata = 8'h5A;
        #1;
        vecs++; if (ldr_ack !== 1'b1) begin errs++; $display("FAIL ldr_wr_ack: got %b want 1", ldr_ack); end
        vecs++; if (mem_we !== 1'b1) begin errs++; $display("FAIL ldr_wr_mem_we: got %b want 1", mem_we); end
        vecs++; if (mem_addr !== 8'h10) begin errs++; $display("FAIL ldr_wr_mem_addr: got %h want 10", mem_addr); end
        vecs++; if (mem_wdata !== 8'h5A) begin errs++; $display("FAIL ldr_wr_mem_wdata: got %h want 5a", mem_wdata); end
        cyc();
        idle();
        #1;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        #1;
        vecs++; if (cpu_ack !== 1'b1) begin errs++; $display("FAIL rd_cpu_ack: got %b want 1", cpu_ack); end
        vecs++; if (cpu_rdata !== 8'h5A) begin errs++; $display("FAIL rd_cpu_rdata: got %h want 5a", cpu_rdata); end
        vecs++; if (ldr_rdata !== 8'h00) begin errs++; $display("FAIL rd_ldr_rdata: got %h want 00", ldr_rdata); end
        vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rd_cpu_stall: got %b want 0", cpu_stall); end
        vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
        cyc();
        vecs++; if (stall_cnt !== 16'h0000) begin errs++; $display("FAIL rd_stall_cnt: got %h want 0000", stall_cnt); end
        idle();
        #1;
    endtask

    // RR: runs of four starting with the CPU; fixed: the CPU every cycle.
    task automatic test_contention();
        logic exp_cpu;
        int   exp_stall;
        do_reset();
        exp_stall = 0;
        cpu_req = 1; cpu_addr = 8'h10;
        ldr_req = 1; ldr_addr = 8'h10;
        for (int i = 0; i < 12; i++) begin
            exp_cpu = RR ? ((i / 4) % 2 == 0) : 1'b1;
            #1;
            vecs++; if (cpu_ack !== exp_cpu) begin errs++; $display("FAIL cont_cpu_ack[%0d]: got %b want %b", i, cpu_ack, exp_cpu); end
            vecs++; if (ldr_ack !== !exp_cpu) begin errs++; $display("FAIL cont_ldr_ack[%0d]: got %b want %b", i, ldr_ack, !exp_cpu); end
            vecs++; if (cpu_rdata !== (exp_cpu ? 8'h5A : 8'h00)) begin errs++; $display("FAIL cont_cpu_rdata[%0d]: got %h", i, cpu_rdata); end
            vecs++; if (ldr_rdata !== (exp_cpu ? 8'h00 : 8'h5A)) begin errs++; $display("FAIL cont_ldr_rdata[%0d]: got %h", i, ldr_rdata); end
            vecs++; if (stall_cnt !== 16'(exp_stall)) begin errs++; $display("FAIL cont_stall_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
            if (!exp_cpu) exp_stall++;
            cyc();
        end
        idle();
        #1;
    endtask

    task automatic test_lock();
        do_reset();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h33; ldr_lock = 1;
        #1;
        vecs++; if (ldr_ack !== 1'b1) begin errs++; $display("FAIL lock_ldr_ack: got %b want 1", ldr_ack); end
        cyc();
        ldr_req = 0; ldr_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        for (int k = 1; k <= 3; k++) begin
            #1;
            vecs++; if (cpu_ack !== 1'b0) begin errs++; $display("FAIL lock_cpu_ack[%0d]: got %b want 0", k, cpu_ack); end
            vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL lock_cpu_stall[%0d]: got %b want 1", k, cpu_stall); end
            vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL lock_mem_we[%0d]: got %b want 0", k, mem_we); end
            vecs++; if (stall_cnt !== 16'(k - 1)) begin errs++; $display("FAIL lock_stall_cnt[%0d]: got %0d want %0d", k, stall_cnt, k - 1); end
            cyc();
        end
        ldr_lock = 0;
        #1;
        vecs++; if (cpu_ack !== 1'b1) begin errs++; $display("FAIL unlock_cpu_ack: got %b want 1", cpu_ack); end
        vecs++; if (cpu_rdata !== 8'h33) begin errs++; $display("FAIL unlock_cpu_rdata: got %h want 33", cpu_rdata); end
        vecs++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL unlock_stall_cnt: got %0d want 3", stall_cnt); end
        cyc();
        idle();
        #1;
    endtask

    task automatic test_back_to_back_write();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h40; ldr_wdata = 8'h22;
        #1;
        vecs++; if (cpu_ack !== 1'b1 || ldr_ack !== 1'b0) begin errs++; $display("FAIL bb_first_ack: got cpu=%b ldr=%b want cpu=1 ldr=0", cpu_ack, ldr_ack); end
        vecs++; if (mem_wdata !== 8'h11) begin errs++; $display("FAIL bb_first_wdata: got %h want 11", mem_wdata); end
        cyc();
        cpu_req = 0; cpu_we = 0;
        #1;
        vecs++; if (ldr_ack !== 1'b1 || cpu_ack !== 1'b0) begin errs++; $display("FAIL bb_second_ack: got cpu=%b ldr=%b want cpu=0 ldr=1", cpu_ack, ldr_ack); end
        vecs++; if (mem_we !== 1'b1 || mem_wdata !== 8'h22) begin errs++; $display("FAIL bb_second_wr: got we=%b data=%h want we=1 data=22", mem_we, mem_wdata); end
        cyc();
        idle();
        cpu_req = 1; cpu_addr = 8'h40;
        #1;
        vecs++; if (cpu_rdata !== 8'h22) begin errs++; $display("FAIL bb_final_ram: got %h want 22", cpu_rdata); end
        cyc();
        idle();
        #1;
    endtask

    task automatic test_reset_mid_write();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h50; ldr_wdata = 8'h77;
        cyc();
        idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h50; cpu_wdata = 8'h99;
        reset = 1;
        #1;
        vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rstmid_mem_we: got %b want 0", mem_we); end
        vecs++; if (cpu_ack !== 1'b0) begin errs++; $display("FAIL rstmid_cpu_ack: got %b want 0", cpu_ack); end
        cyc();
        reset = 0;
        idle();
        #1;
        vecs++; if (stall_cnt !== 16'h0000) begin errs++; $display("FAIL rstmid_stall_cnt: got %h want 0000", stall_cnt); end
        vecs++; if (mem_addr !== 8'h00) begin errs++; $display("FAIL rstmid_mem_addr: got %h want 00", mem_addr); end
        cpu_req = 1; cpu_addr = 8'h50;
        #1;
        vecs++; if (cpu_rdata !== 8'h77) begin errs++; $display("FAIL rstmid_ram_kept: got %h want 77", cpu_rdata); end
        cyc();
        idle();
        #1;
    endtask

    task automatic test_stall_saturate();
        do_reset();
        ldr_req = 1; ldr_lock = 1; ldr_addr = 8'h00;
        #1;
        vecs++; if (ldr_ack !== 1'b1) begin errs++; $display("FAIL sat_lock_ack: got %b want 1", ldr_ack); end
        cyc();
        ldr_req = 0;
        cpu_req = 1; cpu_addr = 8'h10;
        for (int i = 0; i < 70000; i++) begin
            if (i == 65534) begin
                #1;
                vecs++; if (stall_cnt !== 16'hFFFE) begin errs++; $display("FAIL sat_near: got %h want fffe", stall_cnt); end
            end
            cyc();
        end
        #1;
        vecs++; if (stall_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_final: got %h want ffff", stall_cnt); end
        vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL sat_cpu_stall: got %b want 1", cpu_stall); end
        ldr_lock = 0;
        #1;
        vecs++; if (cpu_ack !== 1'b1) begin errs++; $display("FAIL sat_release_ack: got %b want 1", cpu_ack); end
        cyc();
        idle();
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_ldr_write();
        test_cpu_read();
        test_contention();
        test_lock();
        test_back_to_back_write();
        test_reset_mid_write();
        test_stall_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
